// File: rtl/reg_access_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_access_seq                                                  |
// | Purpose  : Serialises operand fetches and writebacks onto the single-port, |
// |            bidirectional reg_bank bus and returns the captured operands    |
// |            over a valid/ready handshake.                                   |
// | Option   : REG_ACCESS_SCOREBOARD_EN adds a pending-writeback mask that     |
// |            stalls fetches of registers still awaiting their writeback.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module reg_access_seq #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [AW-1:0] rn_addr_i,
  input  logic [AW-1:0] rm_addr_i,
  input  logic          use_rm_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          rd_we_i,
  input  logic          wb_valid_i,
  output logic          wb_ready_o,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  output logic          op_valid_o,
  input  logic          op_ready_i,
  output logic [DW-1:0] op_a_o,
  output logic [DW-1:0] op_b_o,
  output logic          rb_trigger_o,
  output logic [AW-1:0] rb_address_o,
  output logic          rb_we_o,
  output logic          rb_oe_o,
  inout  wire  [DW-1:0] rb_data_io
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WB_SET  = 3'd1;
  localparam logic [2:0] S_WB_HOLD = 3'd2;
  localparam logic [2:0] S_RA_SET  = 3'd3;
  localparam logic [2:0] S_RA_CAP  = 3'd4;
  localparam logic [2:0] S_RB_SET  = 3'd5;
  localparam logic [2:0] S_RB_CAP  = 3'd6;
  localparam logic [2:0] S_OUT     = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] wb_data_q;
  logic [AW-1:0] rm_q;
  logic          use_rm_q;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic          trig_q, trig_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic          oe_q, oe_d;
  logic          stall;
  logic          wb_acc;
  logic          req_acc;

  // Handshake decode: writeback always wins over a fetch in IDLE.
  assign wb_ready_o  = (state_q == S_IDLE);
  assign req_ready_o = (state_q == S_IDLE) && !wb_valid_i && !stall;
  assign wb_acc      = wb_valid_i && wb_ready_o;
  assign req_acc     = req_valid_i && req_ready_o;

`ifdef REG_ACCESS_SCOREBOARD_EN
  logic [(1<<AW)-1:0] pend_q, pend_d;

  // Pending mask: writeback accept clears, fetch accept with rd_we sets.
  always_comb begin
    pend_d = pend_q;
    if (wb_acc) begin
      pend_d[wb_addr_i] = 1'b0;
    end else if (req_acc && rd_we_i) begin
      pend_d[rd_addr_i] = 1'b1;
    end
  end

  // Pending mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign stall = pend_q[rn_addr_i] || (use_rm_i && pend_q[rm_addr_i]);
`else
  logic unused_rd;
  assign stall     = 1'b0;
  assign unused_rd = ^{rd_addr_i, rd_we_i};
`endif

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (wb_acc) begin
          state_d = S_WB_SET;
        end else if (req_acc) begin
          state_d = S_RA_SET;
        end
      end
      S_WB_SET:  state_d = S_WB_HOLD;
      S_WB_HOLD: state_d = S_IDLE;
      S_RA_SET:  state_d = S_RA_CAP;
      S_RA_CAP:  state_d = use_rm_q ? S_RB_SET : S_OUT;
      S_RB_SET:  state_d = S_RB_CAP;
      S_RB_CAP:  state_d = S_OUT;
      S_OUT: begin
        if (op_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Bank-side drive follows the state being entered so the pins are registered.
  always_comb begin
    addr_d = addr_q;
    trig_d = trig_q;
    we_d   = (state_d == S_WB_SET) || (state_d == S_WB_HOLD);
    oe_d   = (state_d == S_RA_SET) || (state_d == S_RA_CAP) ||
             (state_d == S_RB_SET) || (state_d == S_RB_CAP);
    case (state_d)
      S_WB_SET: begin
        addr_d = wb_addr_i;
        trig_d = ~trig_q;
      end
      S_RA_SET: begin
        addr_d = rn_addr_i;
        trig_d = ~trig_q;
      end
      S_RB_SET: begin
        addr_d = rm_q;
        trig_d = ~trig_q;
      end
      default: ;
    endcase
  end

  // Operand capture on the edge leaving each CAP state.
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    if (state_q == S_RA_CAP) begin
      op_a_d = rb_data_io;
      if (!use_rm_q) begin
        op_b_d = '0;
      end
    end
    if (state_q == S_RB_CAP) begin
      op_b_d = rb_data_io;
    end
  end

  // State, bus drive and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  // Request fields latched at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data_q <= '0;
      rm_q      <= '0;
      use_rm_q  <= 1'b0;
    end else begin
      if (wb_acc) begin
        wb_data_q <= wb_data_i;
      end
      if (req_acc) begin
        rm_q     <= rm_addr_i;
        use_rm_q <= use_rm_i;
      end
    end
  end

  assign op_valid_o   = (state_q == S_OUT);
  assign op_a_o       = op_a_q;
  assign op_b_o       = op_b_q;
  assign rb_trigger_o = trig_q;
  assign rb_address_o = addr_q;
  assign rb_we_o      = we_q;
  assign rb_oe_o      = oe_q;
  // The data bus is only driven while a write is on the bank.
  assign rb_data_io   = we_q ? wb_data_q : {DW{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_reg_access_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reg_access_seq                                               |
// | Purpose  : Scoreboard bench for reg_access_seq with a reg_bank model.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_reg_access_seq;
  localparam int DW     = 32;
  localparam int AW     = 4;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] rn_addr = '0;
  logic [AW-1:0] rm_addr = '0;
  logic          use_rm = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_we = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a, op_b;
  logic          rb_trigger;
  logic [AW-1:0] rb_address;
  logic          rb_we, rb_oe;
  wire  [DW-1:0] rb_data;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            acc;
    int            lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_regs [16];
  logic [DW-1:0] bank [16];
  int errors = 0, checks = 0;
  int cyc = 0;
  int tog_cnt = 0, exp_tog = 0;
  int last_wb_cyc = 0, prev_wb_cyc = 0, last_fe_cyc = 0, prev_fe_cyc = 0;
  int opr_mode = 0;

  reg_access_seq #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .rn_addr_i(rn_addr), .rm_addr_i(rm_addr), .use_rm_i(use_rm),
    .rd_addr_i(rd_addr), .rd_we_i(rd_we),
    .wb_valid_i(wb_valid), .wb_ready_o(wb_ready),
    .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .op_valid_o(op_valid), .op_ready_i(op_ready),
    .op_a_o(op_a), .op_b_o(op_b),
    .rb_trigger_o(rb_trigger), .rb_address_o(rb_address),
    .rb_we_o(rb_we), .rb_oe_o(rb_oe), .rb_data_io(rb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: drives the bus on reads, stores on write strobes.
  assign rb_data = (rb_oe && !rb_we) ? bank[rb_address] : {DW{1'bz}};
  initial begin
    #1;
    for (int i = 0; i < 16; i++) bank[i] = ref_regs[i];
    forever begin
      @(negedge clk);
      if (!rst && rb_we) bank[rb_address] = rb_data;
    end
  end

  // Consumer: 0 = always ready, 1 = random, 2 = hold off.
  initial begin
    op_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (opr_mode)
        0:       op_ready = 1'b1;
        1:       op_ready = 1'($urandom_range(0, 1));
        default: op_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles, required completion", name, BUDGET);
  endtask

  // Monitor: latency, operand values and bus quiet while operands are held.
  initial begin
    logic prev_ov;
    logic prev_trig;
    exp_t e;
    prev_ov = 1'b0;
    prev_trig = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
        prev_trig = rb_trigger;
      end else begin
        if (rb_trigger !== prev_trig) tog_cnt++;
        prev_trig = rb_trigger;
        if (op_valid) begin
          if (exp_q.size() == 0) begin
            if (!prev_ov) begin
              checks++;
              errors++;
              $display("FAIL op_unexpected: got op_valid=1, required 0 (cycle %0d)", cyc);
            end
          end else begin
            if (!prev_ov) chk("op_latency", cyc - exp_q[0].acc, exp_q[0].lat);
            chk("out_bus_quiet", {rb_oe, rb_we}, 0);
            if (op_ready) begin
              e = exp_q.pop_front();
              chk("op_a", op_a, e.a);
              chk("op_b", op_b, e.b);
            end
          end
        end
        prev_ov = op_valid;
      end
    end
  end

  task automatic send_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    #1;
    while (!wb_ready) begin
      @(negedge clk);
      #1;
      n++;
      if (n > BUDGET) begin
        timeout("wb_accept");
        wb_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    ref_regs[a] = d;
    exp_tog++;
    prev_wb_cyc = last_wb_cyc;
    last_wb_cyc = cyc;
    @(negedge clk);
    chk("wb_ready_set", wb_ready, 0);
    chk("wb_we_set", rb_we, 1);
    chk("wb_addr_set", rb_address, a);
    @(negedge clk);
    chk("wb_ready_hold", wb_ready, 0);
    chk("wb_we_hold", rb_we, 1);
  endtask

  task automatic fetch_wait_accept();
    int n = 0;
    exp_t e;
    while (!req_ready) begin
      @(negedge clk);
      #1;
      n++;
      if (n > BUDGET) begin
        timeout("fetch_accept");
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.a   = ref_regs[rn_addr];
    e.b   = use_rm ? ref_regs[rm_addr] : '0;
    e.acc = cyc;
    e.lat = use_rm ? 4 : 2;
    exp_q.push_back(e);
    exp_tog += (use_rm ? 2 : 1);
    prev_fe_cyc = last_fe_cyc;
    last_fe_cyc = cyc;
  endtask

  task automatic send_fetch(input logic [AW-1:0] rn, input logic [AW-1:0] rm, input logic ur,
                            input logic [AW-1:0] rd, input logic rdwe);
    @(negedge clk);
    req_valid = 1'b1;
    rn_addr = rn;
    rm_addr = rm;
    use_rm  = ur;
    rd_addr = rd;
    rd_we   = rdwe;
    #1;
    fetch_wait_accept();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > BUDGET) begin
        timeout("drain");
        exp_q.delete();
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int t0;
    int n;
    logic [DW-1:0] ea, eb;
    logic rdwe_r;
    for (int i = 0; i < 16; i++) ref_regs[i] = $urandom;
    ref_regs[1] = 32'h11;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_trigger", rb_trigger, 0);
    chk("rst_we", rb_we, 0);
    chk("rst_oe", rb_oe, 0);
    chk("rst_address", rb_address, 0);
    chk("rst_wb_ready", wb_ready, 1);
    chk("rst_req_ready", req_ready, 1);
    rst = 1'b0;

    // Reset in the middle of WB_SET abandons the write
    @(negedge clk);
    wb_valid = 1'b1;
    wb_addr  = 4'd7;
    wb_data  = 32'hDEAD_BEEF;
    #1 chk("midrst_wb_ready", wb_ready, 1);
    @(posedge clk);
    #1 wb_valid = 1'b0;
    #1 chk("midrst_we_before", rb_we, 1);
    chk("midrst_addr_before", rb_address, 7);
    #1 rst = 1'b1;
    #1;
    chk("midrst_we", rb_we, 0);
    chk("midrst_oe", rb_oe, 0);
    chk("midrst_trigger", rb_trigger, 0);
    chk("midrst_op_valid", op_valid, 0);
    chk("midrst_wb_ready", wb_ready, 1);
    chk("midrst_address", rb_address, 0);
    @(negedge clk);
    rst = 1'b0;

    // Writeback r10=5 then a two-operand fetch of r10/r1
    t0 = tog_cnt;
    send_wb(4'd10, 32'd5);
    send_fetch(4'd10, 4'd1, 1'b1, 4'd0, 1'b0);
    wait_drain();
    chk("wbf_toggles", tog_cnt - t0, 3);

    // Single-operand fetch of r15
    t0 = tog_cnt;
    send_fetch(4'd15, 4'd6, 1'b0, 4'd0, 1'b0);
    wait_drain();
    chk("single_toggles", tog_cnt - t0, 1);

    // Simultaneous writeback and fetch of the same register
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = 4'd4; wb_data = 32'hA5A5_0004;
    req_valid = 1'b1; rn_addr = 4'd4; rm_addr = 4'd4; use_rm = 1'b1; rd_we = 1'b0;
    #1;
    chk("simul_wb_ready", wb_ready, 1);
    chk("simul_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    ref_regs[4] = 32'hA5A5_0004;
    exp_tog++;
    last_wb_cyc = cyc;
    fetch_wait_accept();
    chk("simul_fetch_delay", last_fe_cyc - last_wb_cyc, 3);
    wait_drain();

    // Backpressure: operands held four cycles with no bus activity
    opr_mode = 2;
    send_fetch(4'd2, 4'd9, 1'b1, 4'd0, 1'b0);
    ea = ref_regs[2];
    eb = ref_regs[9];
    n = 0;
    while (!op_valid && n <= BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n > BUDGET) timeout("bp_op_valid");
    t0 = tog_cnt;
    repeat (4) begin
      chk("bp_valid", op_valid, 1);
      chk("bp_a", op_a, ea);
      chk("bp_b", op_b, eb);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_wb_ready", wb_ready, 0);
      chk("bp_oe_we", {rb_oe, rb_we}, 0);
      @(negedge clk);
    end
    chk("bp_toggles", tog_cnt - t0, 0);
    opr_mode = 0;
    wait_drain();

    // Throughput: writebacks every 3 cycles, two-operand fetches every 6
    send_wb(4'd2, $urandom);
    send_wb(4'd3, $urandom);
    chk("wb_period", last_wb_cyc - prev_wb_cyc, 3);
    send_fetch(4'd3, 4'd2, 1'b1, 4'd0, 1'b0);
    send_fetch(4'd0, 4'd5, 1'b1, 4'd0, 1'b0);
    chk("fetch_period", last_fe_cyc - prev_fe_cyc, 6);
    wait_drain();

`ifdef REG_ACCESS_SCOREBOARD_EN
    // Scoreboard: fetch of r3 stalls until r3's writeback is accepted
    send_fetch(4'd0, 4'd0, 1'b0, 4'd3, 1'b1);
    wait_drain();
    fork
      send_fetch(4'd3, 4'd5, 1'b1, 4'd0, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          #2 chk("sb_stall", req_ready, 0);
        end
        send_wb(4'd3, 32'hC0FF_EE03);
      end
    join
    wait_drain();
`endif

    // Randomised mix against the reference register file
    opr_mode = 1;
    for (int k = 0; k < 120; k++) begin
`ifdef REG_ACCESS_SCOREBOARD_EN
      rdwe_r = 1'b0;
`else
      rdwe_r = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 99) < 40)
        send_wb(4'($urandom_range(0, 15)), $urandom);
      else
        send_fetch(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rdwe_r);
    end
    opr_mode = 0;
    wait_drain();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 16; i++) chk("bank_contents", bank[i], ref_regs[i]);
    chk("total_toggles", tog_cnt, exp_tog);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
